// File: rtl/cla_add_sequencer_if.sv
// rtl/cla_add_sequencer_if.sv - request/response bundle for the sliced wide adder.
// Optional ovf signal appears when CLA_SEQ_OVF_EN is defined.
interface cla_add_sequencer_if #(
  parameter int WORDS = 4
);
  localparam int WIDE = 16 * WORDS;

  logic            in_valid;
  logic            in_ready;
  logic [WIDE-1:0] a;
  logic [WIDE-1:0] b;
  logic            c_in;
  logic            out_valid;
  logic            out_ready;
  logic [WIDE-1:0] sum;
  logic            c_out;
  logic            busy;
`ifdef CLA_SEQ_OVF_EN
  logic            ovf;
`endif

  modport master (
`ifdef CLA_SEQ_OVF_EN
    input  ovf,
`endif
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, busy
  );

  modport slave (
`ifdef CLA_SEQ_OVF_EN
    output ovf,
`endif
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, busy
  );
endinterface

// File: rtl/cla_add_sequencer.sv
// rtl/cla_add_sequencer.sv - wide adder that time-shares one CLA16 slice, LSW first.
// CLA_SEQ_OVF_EN adds a registered signed-overflow output taken from the last slice.
module cla16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        c_i,
  output logic [15:0] s_o,
`ifdef CLA_SEQ_OVF_EN
  output logic        ovf_o,
`endif
  output logic        co_o
);
  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [3:0]  cg;

  // Carry out of position j of a 4-wide group, fully expanded (no ripple).
  function automatic logic la_carry(input logic [3:0] gv, input logic [3:0] pv,
                                    input logic cin, input logic [1:0] j);
    logic acc;
    logic prod;
    acc  = gv[j];
    prod = pv[j];
    for (int m = int'(j) - 1; m >= 0; m--) begin
      acc  = acc | (prod & gv[m[1:0]]);
      prod = prod & pv[m[1:0]];
    end
    return acc | (prod & cin);
  endfunction

  always_comb begin
    g = a_i & b_i;
    p = a_i ^ b_i;
    for (int k = 0; k < 4; k++) begin
      gg[k] = la_carry(g[4*k +: 4], p[4*k +: 4], 1'b0, 2'd3);
      gp[k] = &p[4*k +: 4];
    end
    cg[0] = c_i;
    cg[1] = la_carry(gg, gp, c_i, 2'd0);
    cg[2] = la_carry(gg, gp, c_i, 2'd1);
    cg[3] = la_carry(gg, gp, c_i, 2'd2);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        c[4*k + j] = la_carry(g[4*k +: 4], p[4*k +: 4], cg[k], 2'(j));
      end
    end
    s_o  = p ^ {c[14:0], c_i};
    co_o = c[15];
  end

`ifdef CLA_SEQ_OVF_EN
  assign ovf_o = c[15] ^ c[14];
`endif
endmodule

module cla_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  cla_add_sequencer_if.slave bus
);
  localparam int WIDE = 16 * WORDS;
  localparam int IW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [WIDE-1:0] a_q, a_d;
  logic [WIDE-1:0] b_q, b_d;
  logic [WIDE-1:0] sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            accept;
  logic [15:0]     slice_a;
  logic [15:0]     slice_b;
  logic [15:0]     slice_s;
  logic            slice_co;
`ifdef CLA_SEQ_OVF_EN
  logic            ovf_q, ovf_d;
  logic            slice_ovf;
`endif

  assign accept  = bus.in_valid & bus.in_ready;
  assign slice_a = a_q[16*idx_q +: 16];
  assign slice_b = b_q[16*idx_q +: 16];

  cla16 u_cla16 (
    .a_i   (slice_a),
    .b_i   (slice_b),
    .c_i   (carry_q),
    .s_o   (slice_s),
`ifdef CLA_SEQ_OVF_EN
    .ovf_o (slice_ovf),
`endif
    .co_o  (slice_co)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q == RUN) || (state_q == DONE);
  end

  // Operands are captured only at accept; sum is cleared so unwritten slices read 0.
  always_comb begin
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef CLA_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (state_q == IDLE && accept) begin
      a_d     = bus.a;
      b_d     = bus.b;
      sum_d   = '0;
      carry_d = bus.c_in;
      idx_d   = '0;
    end else if (state_q == RUN) begin
      for (int w = 0; w < WORDS; w++) begin
        if (idx_q == IW'(w)) sum_d[16*w +: 16] = slice_s;
      end
      carry_d = slice_co;
      idx_d   = idx_q + 1'b1;
      if (idx_q == LAST_IDX) begin
        cout_d = slice_co;
`ifdef CLA_SEQ_OVF_EN
        ovf_d  = slice_ovf;
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef CLA_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.sum   = sum_q;
  assign bus.c_out = cout_q;
`ifdef CLA_SEQ_OVF_EN
  assign bus.ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_cla_add_sequencer.sv
// tb/tb_cla_add_sequencer.sv - directed checks of cla_add_sequencer at WORDS=4 and WORDS=1.
// Overflow checks are compiled in when CLA_SEQ_OVF_EN is defined.
module tb_cla_add_sequencer;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  cla_add_sequencer_if #(.WORDS(4)) bus4 ();
  cla_add_sequencer_if #(.WORDS(1)) bus1 ();

  cla_add_sequencer #(.WORDS(4)) dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4.slave));
  cla_add_sequencer #(.WORDS(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_txn(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic [63:0] exp_sum, input logic exp_cout,
                         input logic exp_ovf, input int hold);
    int lat;
    logic [63:0] held_sum;
    bus4.a = a; bus4.b = b; bus4.c_in = cin;
    bus4.in_valid = 1'b1;
    bus4.out_ready = (hold == 0);
    check({tag, ".in_ready"}, 64'(bus4.in_ready), 64'd1);
    step();
    bus4.in_valid = 1'b0;
    bus4.a = ~a; bus4.b = 64'h1234_5678_9ABC_DEF0; bus4.c_in = ~cin;
    check({tag, ".busy"}, 64'(bus4.busy), 64'd1);
    lat = 0;
    while (!bus4.out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'd4);
    check({tag, ".sum"}, bus4.sum, exp_sum);
    check({tag, ".c_out"}, 64'(bus4.c_out), 64'(exp_cout));
`ifdef CLA_SEQ_OVF_EN
    check({tag, ".ovf"}, 64'(bus4.ovf), 64'(exp_ovf));
`else
    if (exp_ovf === 1'bx) check({tag, ".ovf_unused"}, 64'(exp_ovf), 64'd0);
`endif
    held_sum = bus4.sum;
    if (hold > 0) begin
      bus4.in_valid = 1'b1;
      bus4.a = 64'd5; bus4.b = 64'd6; bus4.c_in = 1'b0;
      for (int i = 0; i < hold; i++) begin
        step();
        check({tag, ".hold_valid"}, 64'(bus4.out_valid), 64'd1);
        check({tag, ".hold_sum"}, bus4.sum, held_sum);
        check({tag, ".hold_in_ready"}, 64'(bus4.in_ready), 64'd0);
      end
      bus4.out_ready = 1'b1;
    end
    step();
    bus4.in_valid = 1'b0;
    check({tag, ".drain_valid"}, 64'(bus4.out_valid), 64'd0);
    check({tag, ".drain_in_ready"}, 64'(bus4.in_ready), 64'd1);
    check({tag, ".drain_busy"}, 64'(bus4.busy), 64'd0);
  endtask

  initial begin
    int seen;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.c_in = 1'b0; bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c_in = 1'b0; bus1.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    check("reset.in_ready", 64'(bus4.in_ready), 64'd1);
    check("reset.out_valid", 64'(bus4.out_valid), 64'd0);
    check("reset.sum", bus4.sum, 64'd0);
    check("reset.c_out", 64'(bus4.c_out), 64'd0);
    check("reset.busy", 64'(bus4.busy), 64'd0);

    run_txn("t1", 64'd1423, 64'd1234, 1'b0, 64'd2657, 1'b0, 1'b0, 0);
    run_txn("t2", 64'd1, 64'd10, 1'b1, 64'd12, 1'b0, 1'b0, 0);
    run_txn("t3", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 0);
    run_txn("ripple", 64'h0000_FFFF_0000_FFFF, 64'd1, 1'b0,
            64'h0000_FFFF_0001_0000, 1'b0, 1'b0, 0);
    run_txn("msb", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
            64'd1, 1'b1, 1'b1, 0);
    run_txn("t4", 64'd1423, 64'd1234, 1'b0, 64'd2657, 1'b0, 1'b0, 5);

    // Abort in the second RUN cycle.
    bus4.a = 64'hFFFF_FFFF_FFFF_FFFF; bus4.b = 64'd1; bus4.c_in = 1'b0;
    bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5.out_valid", 64'(bus4.out_valid), 64'd0);
    check("t5.sum", bus4.sum, 64'd0);
    check("t5.c_out", 64'(bus4.c_out), 64'd0);
    check("t5.in_ready", 64'(bus4.in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus4.out_valid) seen++;
    end
    check("t5.no_result", 64'(seen), 64'd0);

`ifdef CLA_SEQ_OVF_EN
    run_txn("t6", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
            64'h8000_0000_0000_0000, 1'b0, 1'b1, 0);
`endif

    // WORDS=1: a single RUN cycle.
    bus1.a = 16'hFFFF; bus1.b = 16'h0001; bus1.c_in = 1'b0;
    bus1.in_valid = 1'b1; bus1.out_ready = 1'b0;
    check("w1.in_ready", 64'(bus1.in_ready), 64'd1);
    step();
    bus1.in_valid = 1'b0;
    check("w1.not_yet", 64'(bus1.out_valid), 64'd0);
    step();
    check("w1.out_valid", 64'(bus1.out_valid), 64'd1);
    check("w1.sum", 64'(bus1.sum), 64'd0);
    check("w1.c_out", 64'(bus1.c_out), 64'd1);
`ifdef CLA_SEQ_OVF_EN
    check("w1.ovf", 64'(bus1.ovf), 64'd0);
`endif
    bus1.out_ready = 1'b1;
    step();
    check("w1.drain", 64'(bus1.out_valid), 64'd0);

    bus1.a = 16'h1234; bus1.b = 16'h4321; bus1.c_in = 1'b1;
    bus1.in_valid = 1'b1;
    step();
    bus1.in_valid = 1'b0;
    step();
    check("w1b.sum", 64'(bus1.sum), 64'h5556);
    check("w1b.c_out", 64'(bus1.c_out), 64'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
